// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm ringer.
//   ringer_state_t : ringer FSM state encoding
//   BEEP_PATTERN   : per-tick beep enable, bit i = tick index i (double beep at ticks 0 and 2)
package clock_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRing,
    StSnooze
  } ringer_state_t;

  localparam logic [7:0] BEEP_PATTERN = 8'b0000_0101;

endpackage

// File: rtl/alarm_ringer_if.sv
// Signal bundle between the alarm comparator / buttons and the ringer.
//   ring_req, ring_id      : ring event pulse and alarm index
//   stop_btn, snooze_btn   : active-low one-cycle button pulses
//   buzzer                 : gated square wave to the buzzer pin
//   ringing, snoozed       : state flags for display/LEDs
//   active_id, snooze_count: alarm being serviced, snoozes used
//   missed                 : one-cycle pulse on timeout auto-stop
// master drives the requests/buttons, slave is the ringer.
interface alarm_ringer_if;

  logic       ring_req;
  logic [1:0] ring_id;
  logic       stop_btn;
  logic       snooze_btn;
  logic       buzzer;
  logic       ringing;
  logic       snoozed;
  logic [1:0] active_id;
  logic [1:0] snooze_count;
  logic       missed;

  modport master (
    output ring_req, ring_id, stop_btn, snooze_btn,
    input  buzzer, ringing, snoozed, active_id, snooze_count, missed
  );

  modport slave (
    input  ring_req, ring_id, stop_btn, snooze_btn,
    output buzzer, ringing, snoozed, active_id, snooze_count, missed
  );

endinterface

// File: rtl/ringer_prescaler.sv
// Tone and pattern-tick dividers for the alarm ringer.
//   clk, rst_n : clock, asynchronous active-low reset
//   restart    : clear both dividers and force the tone phase high
//   enable     : let the dividers count
//   tone       : tone phase for the coming cycle (registered next-state view)
//   tick       : one-cycle pulse in the last cycle of each pattern tick
module ringer_prescaler #(
  parameter int unsigned TONE_DIV = 25000,
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic tone,
  output logic tick
);

  localparam int unsigned ToneW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [ToneW-1:0] tone_cnt_q, tone_cnt_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tone_q, tone_d;

  always_comb begin
    tone_d     = tone_q;
    tone_cnt_d = tone_cnt_q;
    tick_cnt_d = tick_cnt_q;
    if (restart) begin
      tone_d     = 1'b1;
      tone_cnt_d = '0;
      tick_cnt_d = '0;
    end else if (enable) begin
      if (tone_cnt_q == ToneW'(TONE_DIV - 1)) begin
        tone_cnt_d = '0;
        tone_d     = ~tone_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
      end
      if (tick_cnt_q == TickW'(TICK_DIV - 1)) begin
        tick_cnt_d = '0;
      end else begin
        tick_cnt_d = tick_cnt_q + 1'b1;
      end
    end
  end

  // Tick must not depend on restart: the parent derives restart from tick.
  assign tick = enable & (tick_cnt_q == TickW'(TICK_DIV - 1));
  // Exposing the next phase lets the parent register buzzer in step with it.
  assign tone = tone_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_q     <= 1'b0;
      tone_cnt_q <= '0;
      tick_cnt_q <= '0;
    end else begin
      tone_q     <= tone_d;
      tone_cnt_q <= tone_cnt_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: turns a ring event into a double-beep buzzer pattern with stop, snooze,
// re-ring after the snooze interval and auto-stop after an unattended timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alarm_ringer_if slave (requests/buttons in, buzzer/status out)
// snooze_count is 2 bits wide, so MAX_SNOOZE must not exceed 3.
module alarm_ringer
  import clock_pkg::*;
#(
  parameter int unsigned TONE_DIV       = 25000,
  parameter int unsigned TICK_DIV       = 12500000,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input logic           clk,
  input logic           rst_n,
  alarm_ringer_if.slave bus
);

  localparam int unsigned SecMax = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int unsigned SecW   = $clog2(SecMax + 1);

  ringer_state_t   state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [SecW-1:0] sec_q, sec_d;
  logic [1:0]      id_q, id_d;
  logic [1:0]      snz_q, snz_d;
  logic            ringing_q, snoozed_q, buzzer_q, missed_q, missed_d;
  logic            restart, tone, tick, wrap, sec_done, stop, snooze;
  logic [SecW-1:0] sec_limit;

  ringer_prescaler #(
    .TONE_DIV (TONE_DIV),
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .enable  (state_q != StIdle),
    .tone    (tone),
    .tick    (tick)
  );

  assign stop      = ~bus.stop_btn;
  assign snooze    = ~bus.snooze_btn;
  assign wrap      = tick & (idx_q == 3'd7);
  assign sec_limit = (state_q == StRing) ? SecW'(RING_TIMEOUT_S - 1) : SecW'(SNOOZE_S - 1);
  // The second that is completing right now is the last one allowed in this state.
  assign sec_done  = wrap & (sec_q == sec_limit);

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    snz_d    = snz_q;
    missed_d = 1'b0;
    if (bus.ring_req) begin
      state_d = StRing;
      id_d    = bus.ring_id;
      snz_d   = '0;
    end else begin
      case (state_q)
        StRing: begin
          if (stop) begin
            state_d = StIdle;
          end else if (snooze && (snz_q < 2'(MAX_SNOOZE))) begin
            state_d = StSnooze;
            snz_d   = snz_q + 2'd1;
          end else if (sec_done) begin
            state_d  = StIdle;
            missed_d = 1'b1;
          end
        end
        StSnooze: begin
          if (stop) begin
            state_d = StIdle;
          end else if (sec_done) begin
            state_d = StRing;
          end
        end
        default: ;
      endcase
    end
    if (state_d == StIdle) begin
      id_d  = '0;
      snz_d = '0;
    end

    // Every state entry (and a repeated ring_req) starts the pattern and timing afresh.
    restart = bus.ring_req | (state_d != state_q);

    if (restart) begin
      idx_d = '0;
    end else if (tick) begin
      idx_d = idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end

    if (restart) begin
      sec_d = '0;
    end else if (wrap && (sec_q != SecW'(SecMax))) begin
      sec_d = sec_q + 1'b1;
    end else begin
      sec_d = sec_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      sec_q     <= '0;
      id_q      <= '0;
      snz_q     <= '0;
      ringing_q <= 1'b0;
      snoozed_q <= 1'b0;
      buzzer_q  <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sec_q     <= sec_d;
      id_q      <= id_d;
      snz_q     <= snz_d;
      ringing_q <= (state_d == StRing);
      snoozed_q <= (state_d == StSnooze);
      buzzer_q  <= tone & BEEP_PATTERN[idx_d] & (state_d == StRing);
      missed_q  <= missed_d;
    end
  end

  assign bus.buzzer       = buzzer_q;
  assign bus.ringing      = ringing_q;
  assign bus.snoozed      = snoozed_q;
  assign bus.active_id    = id_q;
  assign bus.snooze_count = snz_q;
  assign bus.missed       = missed_q;

endmodule
